mem_bus_bridge: RTL and testbench

MEM_BUS_BRIDGE -- requirements
Module: mem_bus_bridge

---
 rtl/mem_bus_bridge_pkg.sv | 32 +++
 rtl/mem_bus_bridge_if.sv | 39 +++
 rtl/mem_lane_sel.sv | 32 +++
 rtl/mem_bus_bridge.sv | 108 ++++++++++
 tb/tb_mem_bus_bridge.sv | 180 ++++++++++++++++++
 5 files changed

// File: rtl/mem_bus_bridge_pkg.sv
// Shared types and constants for the processor-to-bus memory bridge.
package mem_bus_bridge_pkg;

    localparam int unsigned ADDR_W          = 32;
    localparam int unsigned DATA_W          = 32;
    localparam int unsigned SEL_W           = 4;
    localparam int unsigned WADDR_W         = ADDR_W - 2;
    localparam int unsigned TIMEOUT_CYC_DEF = 16;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_BUS  = 2'd1,
        ST_DONE = 2'd2,
        ST_ERR  = 2'd3
    } state_e;

    typedef enum logic [1:0] {
        SZ_BYTE = 2'b00,
        SZ_HALF = 2'b01,
        SZ_WORD = 2'b10,
        SZ_RSVD = 2'b11
    } size_e;

    // Everything the bridge presents on the bus for one transfer.
    typedef struct packed {
        logic               we;
        logic [WADDR_W-1:0] addr;
        logic [SEL_W-1:0]   sel;
        logic [DATA_W-1:0]  wdata;
    } bus_req_t;

endpackage

// File: rtl/mem_bus_bridge_if.sv
// Processor-side and bus-side signals of the bridge; slave is the bridge view.
interface mem_bus_bridge_if;
    import mem_bus_bridge_pkg::*;

    logic               Pr_Req_I;
    logic               Pr_We_I;
    logic [1:0]         Pr_Size_I;
    logic [ADDR_W-1:0]  Pr_Addr_I;
    logic [DATA_W-1:0]  Pr_WData_I;
    logic [DATA_W-1:0]  Pr_RData_O;
    logic               Pr_Ack_O;
    logic               Pr_Err_O;
    logic               Pr_Busy_O;

    logic               Bus_Cyc_O;
    logic               Bus_Stb_O;
    logic               Bus_We_O;
    logic [WADDR_W-1:0] Bus_Addr_O;
    logic [SEL_W-1:0]   Bus_Sel_O;
    logic [DATA_W-1:0]  Bus_WData_O;
    logic [DATA_W-1:0]  Bus_RData_I;
    logic               Bus_Ack_I;
    logic               Bus_Err_I;

    modport slave (
        input  Pr_Req_I, Pr_We_I, Pr_Size_I, Pr_Addr_I, Pr_WData_I,
        output Pr_RData_O, Pr_Ack_O, Pr_Err_O, Pr_Busy_O,
        output Bus_Cyc_O, Bus_Stb_O, Bus_We_O, Bus_Addr_O, Bus_Sel_O, Bus_WData_O,
        input  Bus_RData_I, Bus_Ack_I, Bus_Err_I
    );

    modport master (
        output Pr_Req_I, Pr_We_I, Pr_Size_I, Pr_Addr_I, Pr_WData_I,
        input  Pr_RData_O, Pr_Ack_O, Pr_Err_O, Pr_Busy_O,
        input  Bus_Cyc_O, Bus_Stb_O, Bus_We_O, Bus_Addr_O, Bus_Sel_O, Bus_WData_O,
        output Bus_RData_I, Bus_Ack_I, Bus_Err_I
    );

endinterface

// File: rtl/mem_lane_sel.sv
// Big-endian byte-lane decode and alignment check for a sized access.
module mem_lane_sel
    import mem_bus_bridge_pkg::*;
(
    input  logic [1:0]       size,
    input  logic [1:0]       addr_lo,
    output logic [SEL_W-1:0] sel_c,
    output logic             aligned_c
);

    always_comb begin
        sel_c     = '0;
        aligned_c = 1'b0;
        case (size)
            SZ_BYTE: begin
                aligned_c = 1'b1;
                sel_c     = 4'b1000 >> addr_lo;
            end
            SZ_HALF: begin
                aligned_c = ~addr_lo[0];
                sel_c     = addr_lo[1] ? 4'b0011 : 4'b1100;
            end
            SZ_WORD: begin
                aligned_c = (addr_lo == 2'b00);
                sel_c     = 4'b1111;
            end
            default: begin
            end
        endcase
    end

endmodule

// File: rtl/mem_bus_bridge.sv
// Single-outstanding processor-to-bus bridge with lane decode, bus-wait
// timeout, and one-cycle ack/error strobes back to the processor.
module mem_bus_bridge
    import mem_bus_bridge_pkg::*;
#(
    parameter int unsigned TIMEOUT_CYC = TIMEOUT_CYC_DEF
) (
    input  logic             Clk,
    input  logic             Reset,
    mem_bus_bridge_if.slave  bif
);

    localparam int unsigned      CNT_W   = $clog2(TIMEOUT_CYC + 1);
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(TIMEOUT_CYC - 1);

    state_e            state;
    logic [CNT_W-1:0]  wait_cnt;
    bus_req_t          bus_q;
    logic              cyc_q;
    logic [DATA_W-1:0] rdata_q;
    logic              ack_q;
    logic              err_q;
    logic              busy_q;

    logic [SEL_W-1:0]  sel_c;
    logic              aligned_c;

    mem_lane_sel u_lane_sel (
        .size      (bif.Pr_Size_I),
        .addr_lo   (bif.Pr_Addr_I[1:0]),
        .sel_c     (sel_c),
        .aligned_c (aligned_c)
    );

    // Bus request fields are only driven while the cycle is active.
    always_ff @(posedge Clk or negedge Reset) begin
        if (!Reset) begin
            state    <= ST_IDLE;
            wait_cnt <= '0;
            bus_q    <= '0;
            cyc_q    <= 1'b0;
            rdata_q  <= '0;
            ack_q    <= 1'b0;
            err_q    <= 1'b0;
            busy_q   <= 1'b0;
        end else begin
            ack_q <= 1'b0;
            err_q <= 1'b0;
            unique case (state)
                ST_IDLE: begin
                    if (bif.Pr_Req_I) begin
                        busy_q <= 1'b1;
                        if (aligned_c) begin
                            state    <= ST_BUS;
                            cyc_q    <= 1'b1;
                            wait_cnt <= '0;
                            bus_q    <= '{we:    bif.Pr_We_I,
                                          addr:  bif.Pr_Addr_I[ADDR_W-1:2],
                                          sel:   sel_c,
                                          wdata: bif.Pr_WData_I};
                        end else begin
                            state <= ST_ERR;
                        end
                    end
                end
                ST_BUS: begin
                    // Error has priority over a simultaneous acknowledge.
                    if (bif.Bus_Err_I || (!bif.Bus_Ack_I && wait_cnt == CNT_MAX)) begin
                        state <= ST_ERR;
                        cyc_q <= 1'b0;
                        bus_q <= '0;
                    end else if (bif.Bus_Ack_I) begin
                        state <= ST_DONE;
                        cyc_q <= 1'b0;
                        bus_q <= '0;
                        if (!bus_q.we) begin
                            rdata_q <= bif.Bus_RData_I;
                        end
                    end else if (wait_cnt != CNT_MAX) begin
                        wait_cnt <= wait_cnt + CNT_W'(1);
                    end
                end
                ST_DONE: begin
                    state  <= ST_IDLE;
                    ack_q  <= 1'b1;
                    busy_q <= 1'b0;
                end
                ST_ERR: begin
                    state  <= ST_IDLE;
                    err_q  <= 1'b1;
                    busy_q <= 1'b0;
                end
            endcase
        end
    end

    assign bif.Pr_RData_O  = rdata_q;
    assign bif.Pr_Ack_O    = ack_q;
    assign bif.Pr_Err_O    = err_q;
    assign bif.Pr_Busy_O   = busy_q;
    assign bif.Bus_Cyc_O   = cyc_q;
    assign bif.Bus_Stb_O   = cyc_q;
    assign bif.Bus_We_O    = bus_q.we;
    assign bif.Bus_Addr_O  = bus_q.addr;
    assign bif.Bus_Sel_O   = bus_q.sel;
    assign bif.Bus_WData_O = bus_q.wdata;

endmodule

// File: tb/tb_mem_bus_bridge.sv
// Randomized bench for mem_bus_bridge against a transaction-level model.
module tb_mem_bus_bridge;

    localparam int unsigned T = 16;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int   total = 0;
    int   bad = 0;
    logic [31:0] rd_model = '0;

    always #5 clk = ~clk;

    mem_bus_bridge_if bif();

    mem_bus_bridge #(.TIMEOUT_CYC(T)) dut (
        .Clk   (clk),
        .Reset (rst_n),
        .bif   (bif)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%0h exp=%0h @%0t", tag, got, exp, $time);
        end
    endtask

    function automatic bit legal_f(input logic [1:0] sz, input logic [31:0] a);
        case (sz)
            2'd0:    return 1'b1;
            2'd1:    return a[0] == 1'b0;
            2'd2:    return a[1:0] == 2'b00;
            default: return 1'b0;
        endcase
    endfunction

    function automatic logic [3:0] sel_f(input logic [1:0] sz, input logic [31:0] a);
        case (sz)
            2'd0:    return 4'(1 << (3 - int'(a[1:0])));
            2'd1:    return a[1] ? 4'h3 : 4'hC;
            default: return 4'hF;
        endcase
    endfunction

    // kind: 0 = ack, 1 = err, 2 = ack+err together, 3 = bus never answers
    task automatic do_txn(input logic we, input logic [1:0] sz, input logic [31:0] addr,
                          input logic [31:0] wdata, input int waits, input int kind);
        bit legal;
        bit is_ack;
        int stb_n;
        int comp;
        int rd_k;
        logic [31:0] rd_new;
        legal = legal_f(sz, addr);
        rd_k  = -1;
        rd_new = '0;
        if (!legal) begin
            stb_n = 0; comp = 2; is_ack = 1'b0;
        end else if (kind == 3) begin
            stb_n = T; comp = T + 2; is_ack = 1'b0;
        end else begin
            stb_n = waits + 1; comp = waits + 3; is_ack = (kind == 0);
        end
        @(negedge clk);
        bif.Pr_Req_I   = 1'b1;
        bif.Pr_We_I    = we;
        bif.Pr_Size_I  = sz;
        bif.Pr_Addr_I  = addr;
        bif.Pr_WData_I = wdata;
        bif.Bus_Ack_I  = 1'b0;
        bif.Bus_Err_I  = 1'b0;
        for (int k = 1; k <= comp + 1; k++) begin
            @(negedge clk);
            if (k == rd_k) rd_model = rd_new;
            check("cyc",  32'(bif.Bus_Cyc_O), 32'(legal && k <= stb_n));
            check("stb",  32'(bif.Bus_Stb_O), 32'(legal && k <= stb_n));
            if (legal && k <= stb_n) begin
                check("addr", 32'(bif.Bus_Addr_O), 32'(addr[31:2]));
                check("sel",  32'(bif.Bus_Sel_O), 32'(sel_f(sz, addr)));
                check("we",   32'(bif.Bus_We_O), 32'(we));
                if (we) check("wdata", bif.Bus_WData_O, wdata);
            end
            check("ack",   32'(bif.Pr_Ack_O), 32'(is_ack && k == comp));
            check("err",   32'(bif.Pr_Err_O), 32'(!is_ack && k == comp));
            check("busy",  32'(bif.Pr_Busy_O), 32'(k < comp));
            check("rdata", bif.Pr_RData_O, rd_model);
            // Requests while busy must be ignored.
            bif.Pr_Req_I    = (k < comp) ? 1'($urandom_range(0, 1)) : 1'b0;
            bif.Pr_We_I     = 1'($urandom_range(0, 1));
            bif.Pr_Size_I   = 2'($urandom_range(0, 3));
            bif.Pr_Addr_I   = $urandom;
            bif.Pr_WData_I  = $urandom;
            bif.Bus_RData_I = $urandom;
            bif.Bus_Ack_I   = 1'b0;
            bif.Bus_Err_I   = 1'b0;
            if (legal && kind != 3 && k == stb_n) begin
                bif.Bus_Ack_I = (kind == 0 || kind == 2);
                bif.Bus_Err_I = (kind == 1 || kind == 2);
                if (kind == 0 && !we) begin
                    rd_k   = k + 1;
                    rd_new = bif.Bus_RData_I;
                end
            end
        end
    endtask

    initial begin
        bif.Pr_Req_I = 1'b0; bif.Pr_We_I = 1'b0; bif.Pr_Size_I = 2'd0;
        bif.Pr_Addr_I = '0; bif.Pr_WData_I = '0;
        bif.Bus_RData_I = '0; bif.Bus_Ack_I = 1'b0; bif.Bus_Err_I = 1'b0;
        repeat (3) @(negedge clk);
        check("rst_cyc",   32'(bif.Bus_Cyc_O), 32'd0);
        check("rst_stb",   32'(bif.Bus_Stb_O), 32'd0);
        check("rst_ack",   32'(bif.Pr_Ack_O), 32'd0);
        check("rst_err",   32'(bif.Pr_Err_O), 32'd0);
        check("rst_busy",  32'(bif.Pr_Busy_O), 32'd0);
        check("rst_rdata", bif.Pr_RData_O, 32'd0);
        check("rst_sel",   32'(bif.Bus_Sel_O), 32'd0);
        rst_n = 1'b1;

        // Directed scenarios
        do_txn(1'b0, 2'd2, 32'h0000_1004, 32'h0, 1, 0);
        check("word_rd_data", bif.Pr_RData_O, rd_model);
        do_txn(1'b1, 2'd0, 32'h0000_0013, 32'h0000_00AB, 0, 0);
        do_txn(1'b0, 2'd1, 32'h0000_0001, 32'h0, 0, 0);
        do_txn(1'b0, 2'd3, 32'h0000_0000, 32'h0, 0, 0);
        do_txn(1'b0, 2'd2, 32'h0000_0040, 32'h0, 0, 3);
        do_txn(1'b0, 2'd2, 32'h0000_0044, 32'h0, 2, 2);
        do_txn(1'b1, 2'd1, 32'h0000_0082, 32'h1234_5678, 3, 1);
        do_txn(1'b0, 2'd1, 32'h0000_0086, 32'h0, T - 1, 0);

        // Reset during the third bus-wait cycle
        @(negedge clk);
        bif.Pr_Req_I = 1'b1; bif.Pr_We_I = 1'b0; bif.Pr_Size_I = 2'd2;
        bif.Pr_Addr_I = 32'h0000_0100;
        @(negedge clk);
        bif.Pr_Req_I = 1'b0;
        repeat (2) @(negedge clk);
        check("pre_rst_cyc", 32'(bif.Bus_Cyc_O), 32'd1);
        #2 rst_n = 1'b0;
        #1;
        rd_model = '0;
        check("mid_rst_cyc",   32'(bif.Bus_Cyc_O), 32'd0);
        check("mid_rst_stb",   32'(bif.Bus_Stb_O), 32'd0);
        check("mid_rst_busy",  32'(bif.Pr_Busy_O), 32'd0);
        check("mid_rst_rdata", bif.Pr_RData_O, rd_model);
        @(negedge clk);
        rst_n = 1'b1;
        bif.Bus_Ack_I = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            check("post_rst_ack", 32'(bif.Pr_Ack_O), 32'd0);
            check("post_rst_err", 32'(bif.Pr_Err_O), 32'd0);
        end
        bif.Bus_Ack_I = 1'b0;
        do_txn(1'b0, 2'd2, 32'h0000_0200, 32'h0, 0, 0);

        // Randomized traffic
        for (int n = 0; n < 150; n++) begin
            logic [31:0] a;
            logic [1:0]  sz;
            int          kind;
            int          w;
            int          r;
            a  = $urandom;
            sz = 2'($urandom_range(0, 3));
            if ($urandom_range(0, 3) != 0) a[1:0] = 2'b00;
            r = int'($urandom_range(0, 19));
            kind = (r < 13) ? 0 : (r < 16) ? 1 : (r < 19) ? 2 : 3;
            w = ($urandom_range(0, 9) == 0) ? int'(T - 1) : int'($urandom_range(0, 4));
            do_txn(1'($urandom_range(0, 1)), sz, a, $urandom, w, kind);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
